prefetch_queue: RTL and testbench



---
 rtl/prefetch_queue_pkg.sv | 19 +
 rtl/prefetch_queue_sync_fifo.sv | 89 ++++++++
 rtl/prefetch_queue.sv | 166 ++++++++++++++++
 tb/tb_prefetch_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/prefetch_queue_sync_fifo.sv
// Synchronous FIFO with registered head, flush-over-everything priority,
// and simultaneous push/pop allowed while full.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so full+pop+push is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Occupancy must never exceed the number of slots.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CW'(DEPTH));
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers the
// returned words with their PCs and presents the oldest to the fetch stage.
// Redirects flush the queue and discard responses still in flight.
// Optional macro IFQ_BYPASS_EN: a response arriving at an empty queue is
// forwarded to ifq_* combinationally in the same cycle.
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter  int                DEPTH    = 4,
    parameter  int                MAX_OUT  = 2,
    parameter  logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int                CW       = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               ifq_valid,
    input  logic               ifq_ready,
    output logic [INSTR_W-1:0] ifq_instr,
    output logic [ADDR_W-1:0]  ifq_pc,
    output logic [CW-1:0]      ifq_count
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    ifq_entry_t        push_entry;
    ifq_entry_t        head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_live;
    logic              rsp_keep;
    logic              byp_take;
    logic              fifo_push;
    logic              fifo_pop;

    // Slots already promised = stored words + live requests in flight.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};

    assign imem_req_valid = !reset && !redirect_valid
                         && (outstanding_q < CW'(MAX_OUT))
                         && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding belong to pre-reset requests.
    assign rsp_live = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep = rsp_live && (drop_cnt_q == '0) && !redirect_valid && !reset;

`ifdef IFQ_BYPASS_EN
    assign byp_take = rsp_keep && fifo_empty && ifq_ready;
`else
    assign byp_take = 1'b0;
`endif

    assign fifo_push  = rsp_keep && !byp_take;
    assign fifo_pop   = ifq_ready && !fifo_empty && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign ifq_count  = fifo_count;

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef IFQ_BYPASS_EN
    // Head presentation, forwarding a fresh response straight through an empty queue.
    always_comb begin
        ifq_valid = 1'b0;
        ifq_instr = '0;
        ifq_pc    = '0;
        if (!fifo_empty) begin
            ifq_valid = 1'b1;
            ifq_instr = head_entry.instr;
            ifq_pc    = head_entry.pc;
        end else if (rsp_keep) begin
            ifq_valid = 1'b1;
            ifq_instr = imem_rsp_data;
            ifq_pc    = rsp_pc_q;
        end
    end
`else
    // Head presentation from the registered queue only; zeros while empty.
    always_comb begin
        ifq_valid = 1'b0;
        ifq_instr = '0;
        ifq_pc    = '0;
        if (!fifo_empty) begin
            ifq_valid = 1'b1;
            ifq_instr = head_entry.instr;
            ifq_pc    = head_entry.pc;
        end
    end
`endif

    // Fetch/response PCs and in-flight bookkeeping; redirect takes priority.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q - CW'(rsp_live) + CW'(req_fire);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            // Everything still in flight after this edge is stale.
            drop_cnt_d = outstanding_q - CW'(rsp_live);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_live && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // The credit rule must leave a slot for every kept response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
            assert (drop_cnt_q <= outstanding_q);
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue (DEPTH=4, MAX_OUT=2).
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ifq_valid;
    logic        ifq_ready = 1'b0;
    logic [31:0] ifq_instr;
    logic [31:0] ifq_pc;
    logic [2:0]  ifq_count;

    int errors = 0;
    int checks = 0;
    int nreq   = 0;
    bit auto_mem = 1'b0;

    always #5 clk = ~clk;

    prefetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ifq_valid      (ifq_valid),
        .ifq_ready      (ifq_ready),
        .ifq_instr      (ifq_instr),
        .ifq_pc         (ifq_pc),
        .ifq_count      (ifq_count)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; auto_mem answers each accepted request on the following cycle.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) nreq++;
        if (auto_mem) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hs ? instr_of(a) : 32'h0;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic reset_dut();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        ifq_ready      = 1'b0;
        auto_mem       = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values, observed while reset is still asserted.
        tick();
        tick();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_ifq_valid", {31'b0, ifq_valid}, 32'h0);
        check("rst_count", {29'b0, ifq_count}, 32'h0);
        check("rst_ifq_pc", ifq_pc, 32'h0);
        check("rst_ifq_instr", ifq_instr, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_req_addr", imem_req_addr, 32'h0);

        // Streaming: 1-cycle memory, fetch stage always ready.
        imem_req_ready = 1'b1;
        ifq_ready      = 1'b1;
        auto_mem       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stream_req_valid", {31'b0, imem_req_valid}, 32'h1);
            check("stream_req_addr", imem_req_addr, 32'(4 * i));
            tick();
            if (i == 0) begin
                check("stream_first_latency", {31'b0, ifq_valid}, 32'h0);
            end else begin
                check("stream_ifq_valid", {31'b0, ifq_valid}, 32'h1);
                check("stream_ifq_pc", ifq_pc, 32'(4 * (i - 1)));
                check("stream_ifq_instr", ifq_instr, instr_of(32'(4 * (i - 1))));
                check("stream_count", {29'b0, ifq_count}, 32'h1);
            end
        end

        // Fetch stage stalled: credit limit stops issue at 4 entries.
        reset_dut();
        nreq           = 0;
        imem_req_ready = 1'b1;
        auto_mem       = 1'b1;
        repeat (8) tick();
        check("fill_nreq", 32'(nreq), 32'd4);
        check("fill_count", {29'b0, ifq_count}, 32'd4);
        check("fill_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("fill_head_pc", ifq_pc, 32'h0);
        check("fill_head_instr", ifq_instr, instr_of(32'h0));
        ifq_ready = 1'b1;
        tick();
        ifq_ready = 1'b0;
        check("pop_count", {29'b0, ifq_count}, 32'd3);
        check("pop_head_pc", ifq_pc, 32'h4);
        repeat (6) tick();
        check("refill_nreq", 32'(nreq), 32'd5);
        check("refill_count", {29'b0, ifq_count}, 32'd4);
        check("refill_req_valid", {31'b0, imem_req_valid}, 32'h0);

        // Stray response with nothing outstanding, then redirect discards in-flight words.
        reset_dut();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_0000;
        tick();
        check("stray_rsp_count", {29'b0, ifq_count}, 32'h0);
        check("stray_rsp_valid", {31'b0, ifq_valid}, 32'h0);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        #1;
        check("redir_blocks_req", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        check("redir_addr_10", imem_req_addr, 32'h10);
        tick();
        check("redir_addr_14", imem_req_addr, 32'h14);
        tick();
        check("max_out_block", {31'b0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        check("redir_addr_100", imem_req_addr, 32'h100);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0010;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0014;
        tick();
        check("drop_count", {29'b0, ifq_count}, 32'h0);
        check("drop_valid", {31'b0, ifq_valid}, 32'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_0100;
        tick();
        check("redir_head_valid", {31'b0, ifq_valid}, 32'h1);
        check("redir_head_pc", ifq_pc, 32'h100);
        check("redir_head_instr", ifq_instr, 32'h1234_0100);

        // Redirect coinciding with a response and a pop.
        reset_dut();
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hAAAA_0000;
        tick();
        tick();
        check("pre_redir_count", {29'b0, ifq_count}, 32'h1);
        check("pre_redir_pc", ifq_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hAAAA_0004;
        ifq_ready      = 1'b1;
        #1;
        check("redir_rsp_no_req", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        ifq_ready      = 1'b0;
        imem_req_ready = 1'b0;
        check("redir_rsp_count", {29'b0, ifq_count}, 32'h0);
        check("redir_rsp_valid", {31'b0, ifq_valid}, 32'h0);
        check("redir_rsp_pc_empty", ifq_pc, 32'h0);
        check("redir_rsp_addr", imem_req_addr, 32'h200);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hAAAA_0008;
        tick();
        check("stale_dropped", {29'b0, ifq_count}, 32'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBBBB_0200;
        tick();
        check("post_redir_pc", ifq_pc, 32'h200);
        check("post_redir_instr", ifq_instr, 32'hBBBB_0200);

        // Address wrap past 0xFFFF_FFFC.
        reset_dut();
        auto_mem       = 1'b1;
        ifq_ready      = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", imem_req_addr, 32'h0);
        tick();
        check("wrap_pc_top", ifq_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", ifq_instr, instr_of(32'hFFFF_FFFC));
        tick();
        check("wrap_pc_zero", ifq_pc, 32'h0);

        // Response arriving at an empty queue with the fetch stage ready.
        reset_dut();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hC000_0008;
        ifq_ready      = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_valid", {31'b0, ifq_valid}, 32'h1);
        check("byp_instr", ifq_instr, 32'hC000_0008);
        check("byp_pc", ifq_pc, 32'h20);
        tick();
        check("byp_count", {29'b0, ifq_count}, 32'h0);
        check("byp_after_valid", {31'b0, ifq_valid}, 32'h0);
`else
        check("nobyp_same_cycle", {31'b0, ifq_valid}, 32'h0);
        tick();
        check("nobyp_valid", {31'b0, ifq_valid}, 32'h1);
        check("nobyp_pc", ifq_pc, 32'h20);
        check("nobyp_instr", ifq_instr, 32'hC000_0008);
        check("nobyp_count", {29'b0, ifq_count}, 32'h1);
`endif
        ifq_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
